dma_copy_afu: RTL

// - Application stage below the CCI DMA wrapper. Software programs the copy through MMIO

---
 rtl/dma_copy_afu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_copy_afu.sv
// dma_copy_afu: MMIO-programmed copy engine sitting below the CCI DMA wrapper.
// Read-channel lines are buffered in a first-word-fall-through FIFO and replayed
// to the write channel; completion and a cycle count are reported through MMIO.
module dma_copy_afu #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42,
    parameter int SIZE_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int MMIO_AW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mmio_wr_en,
    input  logic [MMIO_AW-1:0]    mmio_wr_addr,
    input  logic [63:0]           mmio_wr_data,
    input  logic                  mmio_rd_en,
    input  logic [MMIO_AW-1:0]    mmio_rd_addr,
    output logic [63:0]           mmio_rd_data,
    output logic                  mmio_rd_valid,
    output logic                  rd_go,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_done,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    output logic                  wr_go,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [SIZE_WIDTH-1:0] wr_size,
    input  logic                  wr_done,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_valid,
    input  logic                  wr_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [MMIO_AW-1:0] CSR_GO     = MMIO_AW'('h50);
    localparam logic [MMIO_AW-1:0] CSR_RDADDR = MMIO_AW'('h52);
    localparam logic [MMIO_AW-1:0] CSR_WRADDR = MMIO_AW'('h54);
    localparam logic [MMIO_AW-1:0] CSR_SIZE   = MMIO_AW'('h56);
    localparam logic [MMIO_AW-1:0] CSR_DONE   = MMIO_AW'('h58);
    localparam logic [MMIO_AW-1:0] CSR_CYCLES = MMIO_AW'('h5A);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE_ST} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic                    done_q;
    logic [63:0]             cycles_q;
    logic                    rd_flag_q, wr_flag_q;
    logic [SIZE_WIDTH-1:0]   lines_q;
    logic                    rd_go_q, wr_go_q;
    logic [63:0]             mmio_rd_data_q, rd_mux_d;
    logic                    mmio_rd_valid_q;
    logic                    rdy_en_q;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]          wptr_q, rptr_q;
    logic                    fifo_full, fifo_empty, push, pop;
    logic                    go_wr, go_accept, idle;
    logic                    unused_wr_bits;

    assign unused_wr_bits = ^mmio_wr_data;

    assign idle      = (state_q == IDLE);
    assign go_wr     = mmio_wr_en && (mmio_wr_addr == CSR_GO) && mmio_wr_data[0];
    assign go_accept = go_wr && idle;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

    // rdy_en_q holds rd_ready low while in reset so every output reads 0 there
    assign rd_ready = rdy_en_q && !fifo_full;
    assign wr_valid = !fifo_empty;
    assign push     = rd_valid && rd_ready;
    assign pop      = wr_valid && wr_ready;
    assign wr_data  = fifo_empty ? '0 : mem[rptr_q[PTR_W-1:0]];

    assign rd_go         = rd_go_q;
    assign wr_go         = wr_go_q;
    assign rd_addr       = rd_addr_q;
    assign wr_addr       = wr_addr_q;
    assign rd_size       = size_q;
    assign wr_size       = size_q;
    assign mmio_rd_data  = mmio_rd_data_q;
    assign mmio_rd_valid = mmio_rd_valid_q;

    // Copy sequencer: go pulses, sticky done flags, completion and cycle count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_go_q   <= 1'b0;
            wr_go_q   <= 1'b0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
            rd_flag_q <= 1'b0;
            wr_flag_q <= 1'b0;
        end else begin
            rd_go_q <= 1'b0;
            wr_go_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_wr) begin
                        done_q    <= 1'b0;
                        cycles_q  <= '0;
                        rd_flag_q <= 1'b0;
                        wr_flag_q <= 1'b0;
                        if (size_q == '0) begin
                            state_q <= DONE_ST;
                        end else begin
                            state_q <= START;
                            rd_go_q <= 1'b1;
                            wr_go_q <= 1'b1;
                        end
                    end
                end
                START: state_q <= BUSY;
                BUSY: begin
                    if (rd_flag_q && wr_flag_q && (lines_q == size_q))
                        state_q <= DONE_ST;
                end
                DONE_ST: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (state_q == START || state_q == BUSY) begin
                if (cycles_q != '1) cycles_q <= cycles_q + 64'd1;
                if (rd_done) rd_flag_q <= 1'b1;
                if (wr_done) wr_flag_q <= 1'b1;
            end
        end
    end

    // Configuration CSRs, writable only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            size_q    <= '0;
        end else if (mmio_wr_en && idle) begin
            case (mmio_wr_addr)
                CSR_RDADDR: rd_addr_q <= mmio_wr_data[ADDR_WIDTH-1:0];
                CSR_WRADDR: wr_addr_q <= mmio_wr_data[ADDR_WIDTH-1:0];
                CSR_SIZE:   size_q    <= mmio_wr_data[SIZE_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // CSR read mux from current register values (old value on same-cycle write)
    always_comb begin
        rd_mux_d = '0;
        case (mmio_rd_addr)
            CSR_RDADDR: rd_mux_d = 64'(rd_addr_q);
            CSR_WRADDR: rd_mux_d = 64'(wr_addr_q);
            CSR_SIZE:   rd_mux_d = 64'(size_q);
            CSR_DONE:   rd_mux_d = {63'd0, done_q};
            CSR_CYCLES: rd_mux_d = cycles_q;
            default:    rd_mux_d = '0;
        endcase
    end

    // One-cycle MMIO read response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmio_rd_valid_q <= 1'b0;
            mmio_rd_data_q  <= '0;
            rdy_en_q        <= 1'b0;
        end else begin
            mmio_rd_valid_q <= mmio_rd_en;
            mmio_rd_data_q  <= mmio_rd_en ? rd_mux_d : '0;
            rdy_en_q        <= 1'b1;
        end
    end

    // FIFO pointers and lines-written counter; reset flushes the buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            lines_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (go_accept)  lines_q <= '0;
            else if (pop)   lines_q <= lines_q + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[PTR_W-1:0]] <= rd_data;
    end

endmodule
